// File: rtl/sram_port_initiator_pkg.sv
// Shared types and constants for the SRAM port initiator and its response buffer.
package sram_if_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } init_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/sram_port_initiator_if.sv
// Request/response stream bundle between the cache datapath (master) and the SRAM port initiator (slave).
interface sram_port_initiator_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wmask, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Two-entry response buffer for SRAM read data; simultaneous push and pop keep the count unchanged.
module sram_rsp_fifo
  import sram_if_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  // The credit rule upstream guarantees a push never lands on a full buffer.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == FIFO_CNT_W'(FIFO_DEPTH))));

endmodule

// File: rtl/sram_port_initiator.sv
// Drives a single-port OpenRAM array from a valid/ready request stream: zero-fills the array after
// reset, then issues reads/writes and returns read data in order through a 2-entry buffer.
module sram_port_initiator
  import sram_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_initiator_if.slave  bus,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  init_state_e           state;
  init_state_e           state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  inflight;
  logic                  accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT;
      init_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      inflight <= accept && !bus.req_we;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    state_nxt = INIT;
      INIT:    if (init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = WAIT;
    endcase
  end

  // One credit per outstanding read: buffered data plus the read currently in the SRAM.
  assign bus.req_ready = (state == RUN) &&
                         ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  assign accept        = bus.req_valid && bus.req_ready;
  assign init_done     = (state == RUN);

  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (state == INIT) begin
      csb0   = 1'b0;
      web0   = 1'b0;
      wmask0 = '1;
      addr0  = init_cnt;
    end else if (accept) begin
      csb0  = 1'b0;
      web0  = ~bus.req_we;
      addr0 = bus.req_addr;
      if (bus.req_we) begin
        wmask0 = bus.req_wmask;
        din0   = bus.req_wdata;
      end
    end
  end

  // Read data bypasses the empty buffer so a response appears the cycle after issue.
  assign fifo_empty    = (fifo_count == '0);
  assign fifo_pop      = bus.rsp_ready && !fifo_empty;
  assign fifo_push     = inflight && !(fifo_empty && bus.rsp_ready);
  assign bus.rsp_valid = !fifo_empty || inflight;
  assign bus.rsp_rdata = fifo_empty ? dout0 : fifo_head;

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dout0),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_sram_port_initiator.sv
// Randomized self-checking bench: behavioural SRAM plus a queue/array reference of the initiator.
module tb_sram_port_initiator;

  localparam int AW    = 4;
  localparam int DW    = 256;
  localparam int NW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          csb0;
  logic          web0;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  always #5 clk = ~clk;

  sram_port_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) bus ();

  sram_port_initiator #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WMASKS (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  // Behavioural single-port SRAM: inputs registered at posedge, one-cycle read data.
  logic [DW-1:0] sram_mem [DEPTH];
  bit            scramble = 1'b1;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++)
        for (int w = 0; w < DW / 32; w++)
          sram_mem[i][32*w +: 32] <= $urandom();
    end else if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < NW; b++)
          if (wmask0[b]) sram_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram_mem[addr0];
      end
    end
  end

  // Reference model: init progress, array contents, and reads awaiting delivery.
  int            init_cnt;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            acc_last;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    return (init_cnt == DEPTH) && (exp_q.size() < 2);
  endfunction

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [NW-1:0] mask);
    logic [DW-1:0] r = old_w;
    for (int b = 0; b < NW; b++)
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic reset_model();
    init_cnt = -1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic check_outputs();
    logic          e_csb = 1'b1;
    logic          e_web = 1'b1;
    logic [NW-1:0] e_mask = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0;
    if (init_cnt >= 0 && init_cnt < DEPTH) begin
      e_csb  = 1'b0;
      e_web  = 1'b0;
      e_mask = '1;
      e_addr = AW'(init_cnt);
    end else if (exp_ready() && bus.req_valid) begin
      e_csb  = 1'b0;
      e_web  = ~bus.req_we;
      e_addr = bus.req_addr;
      if (bus.req_we) begin
        e_mask = bus.req_wmask;
        e_din  = bus.req_wdata;
      end
    end
    check_val("csb0", DW'(csb0), DW'(e_csb));
    check_val("web0", DW'(web0), DW'(e_web));
    check_val("wmask0", DW'(wmask0), DW'(e_mask));
    check_val("addr0", DW'(addr0), DW'(e_addr));
    check_val("din0", din0, e_din);
    check_val("init_done", DW'(init_done), DW'(init_cnt == DEPTH));
    check_val("req_ready", DW'(bus.req_ready), DW'(exp_ready()));
    check_val("rsp_valid", DW'(bus.rsp_valid), DW'(exp_q.size() > 0));
    if (exp_q.size() > 0) check_val("rsp_rdata", bus.rsp_rdata, exp_q[0]);
  endtask

  task automatic update_model();
    bit rdy;
    acc_last = 1'b0;
    if (!rst_n) return;
    if (init_cnt < DEPTH) begin
      init_cnt++;
      return;
    end
    rdy = exp_ready();
    if (exp_q.size() > 0 && bus.rsp_ready) void'(exp_q.pop_front());
    if (rdy && bus.req_valid) begin
      acc_last = 1'b1;
      if (bus.req_we)
        ref_mem[bus.req_addr] = merge_bytes(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask);
      else
        exp_q.push_back(ref_mem[bus.req_addr]);
    end
  endtask

  task automatic cycle();
    @(negedge clk) check_outputs();
    @(posedge clk) update_model();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
  endtask

  // Holds a request until accepted; optionally opens rsp_ready after rel stalled cycles.
  task automatic send(input bit we, input logic [AW-1:0] a, input logic [NW-1:0] m,
                      input logic [DW-1:0] d, input int rel, output int waits);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    waits = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == rel) bus.rsp_ready = 1'b1;
      cycle();
      if (acc_last) break;
      waits++;
    end
    check_val("req_accepted", DW'(acc_last), DW'(1));
    idle_inputs();
  endtask

  task automatic random_inputs();
    bus.req_valid = ($urandom_range(0, 3) != 0);
    bus.req_we    = $urandom_range(0, 1) == 1;
    bus.req_addr  = AW'($urandom());
    bus.req_wmask = NW'($urandom());
    for (int w = 0; w < DW / 32; w++) bus.req_wdata[32*w +: 32] = $urandom();
    bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic run_init();
    rst_n = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  int waits;

  initial begin
    idle_inputs();
    bus.rsp_ready = 1'b0;
    reset_model();
    repeat (3) cycle();
    scramble = 1'b0;
    run_init();

    // Fresh read after zero-fill.
    bus.rsp_ready = 1'b1;
    send(1'b0, 4'd5, '0, '0, -1, waits);
    @(negedge clk);
    check_val("rd5_valid", DW'(bus.rsp_valid), DW'(1));
    check_val("rd5_data", bus.rsp_rdata, '0);
    check_outputs();
    @(posedge clk) update_model();
    #1;

    // Partial write followed immediately by a read of the same word.
    send(1'b1, 4'd3, 32'h0000_000F, {32{8'hA5}}, -1, waits);
    send(1'b0, 4'd3, '0, '0, -1, waits);
    @(negedge clk);
    check_val("wr_rd_data", bus.rsp_rdata, {224'd0, 32'hA5A5_A5A5});
    check_outputs();
    @(posedge clk) update_model();
    #1;
    repeat (2) cycle();

    // Backpressure: two credits only, then in-order drain.
    bus.rsp_ready = 1'b0;
    send(1'b1, 4'd1, '1, {8{32'h1111_0001}}, -1, waits);
    send(1'b1, 4'd2, '1, {8{32'h2222_0002}}, -1, waits);
    send(1'b1, 4'd4, '1, {8{32'h4444_0004}}, -1, waits);
    send(1'b0, 4'd1, '0, '0, -1, waits);
    send(1'b0, 4'd2, '0, '0, -1, waits);
    send(1'b0, 4'd3, '0, '0, 4, waits);
    check_val("bp_stall", DW'(waits >= 4), DW'(1));
    send(1'b0, 4'd4, '0, '0, -1, waits);
    repeat (4) cycle();

    // Streaming reads at full rate.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(1'b0, AW'($urandom()), '0, '0, -1, waits);
      check_val("stream_no_stall", DW'(waits), DW'(0));
    end
    repeat (2) cycle();

    // Free-running random traffic.
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      cycle();
    end
    idle_inputs();
    bus.rsp_ready = 1'b0;
    repeat (3) cycle();

    // Reset with two responses buffered.
    send(1'b0, 4'd7, '0, '0, -1, waits);
    send(1'b0, 4'd8, '0, '0, -1, waits);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    check_val("rst_csb0", DW'(csb0), DW'(1));
    check_val("rst_req_ready", DW'(bus.req_ready), DW'(0));
    check_val("rst_init_done", DW'(init_done), DW'(0));
    reset_model();
    @(posedge clk);
    #1;
    repeat (2) cycle();
    run_init();
    for (int i = 0; i < 150; i++) begin
      random_inputs();
      cycle();
    end
    idle_inputs();
    bus.rsp_ready = 1'b1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
